// File: rtl/idiv_unit_if.sv
// Coprocessor handshake between the board host and the integer divide unit.
// The host drives operands, op code and istart; the unit returns oresult/oready.
interface idiv_unit_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] idataa;
  logic [WIDTH-1:0] idatab;
  logic [4:0]       icontrol;
  logic             istart;
  logic [WIDTH-1:0] oresult;
  logic             oready;

  modport master (
    output idataa, idatab, icontrol, istart,
    input  oresult, oready
  );

  modport slave (
    input  idataa, idatab, icontrol, istart,
    output oresult, oready
  );
endinterface

// File: rtl/idiv_unit.sv
// Iterative radix-2 restoring divide/remainder unit, one quotient bit per clock.
// Signed ops divide magnitudes and fix the sign of the result on the last iteration.
module idiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic       iclock,
  input  logic       ireset,
  idiv_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dsr_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] result_r;
  logic             ready_r;
  logic             is_rem_r;
  logic             qneg_r;
  logic             rneg_r;

  logic             op_valid_s;
  logic             op_signed_s;
  logic             op_rem_s;
  logic             div_zero_s;
  logic [WIDTH-1:0] a_abs_s;
  logic [WIDTH-1:0] b_abs_s;
  logic [WIDTH:0]   shift_s;
  logic [WIDTH:0]   diff_s;
  logic             qbit_s;
  logic [WIDTH-1:0] rem_nxt_s;
  logic [WIDTH-1:0] quo_nxt_s;
  logic [WIDTH-1:0] final_s;
  logic             last_iter_s;

  // Request decode and operand magnitudes, evaluated while idle.
  always_comb begin
    op_valid_s  = (bus.icontrol[4:2] == 3'd0);
    op_signed_s = ~bus.icontrol[0];
    op_rem_s    = bus.icontrol[1];
    div_zero_s  = (bus.idatab == '0);
    a_abs_s     = (op_signed_s && bus.idataa[WIDTH-1]) ? -bus.idataa : bus.idataa;
    b_abs_s     = (op_signed_s && bus.idatab[WIDTH-1]) ? -bus.idatab : bus.idatab;
  end

  // One restoring step; the partial remainder stays below the divisor, so 33 bits suffice.
  always_comb begin
    shift_s     = {rem_r, dvd_r[WIDTH-1]};
    diff_s      = shift_s - {1'b0, dsr_r};
    qbit_s      = ~diff_s[WIDTH];
    rem_nxt_s   = qbit_s ? diff_s[WIDTH-1:0] : shift_s[WIDTH-1:0];
    quo_nxt_s   = {dvd_r[WIDTH-2:0], qbit_s};
    last_iter_s = (cnt_r == CW'(WIDTH - 1));
    if (is_rem_r) begin
      final_s = rneg_r ? -rem_nxt_s : rem_nxt_s;
    end else begin
      final_s = qneg_r ? -quo_nxt_s : quo_nxt_s;
    end
  end

  // State register.
  always_ff @(posedge iclock) begin
    if (ireset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; istart must be seen low in DONE before another request is taken.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.istart && op_valid_s && !div_zero_s) begin
          state_nxt_s = ST_BUSY;
        end else if (bus.istart) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (last_iter_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (bus.istart) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge iclock) begin
    if (ireset) begin
      cnt_r    <= '0;
      dvd_r    <= '0;
      dsr_r    <= '0;
      rem_r    <= '0;
      result_r <= '0;
      ready_r  <= 1'b0;
      is_rem_r <= 1'b0;
      qneg_r   <= 1'b0;
      rneg_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          ready_r <= 1'b0;
          if (bus.istart) begin
            dvd_r    <= a_abs_s;
            dsr_r    <= b_abs_s;
            rem_r    <= '0;
            cnt_r    <= '0;
            is_rem_r <= op_rem_s;
            qneg_r   <= op_signed_s & (bus.idataa[WIDTH-1] ^ bus.idatab[WIDTH-1]);
            rneg_r   <= op_signed_s & bus.idataa[WIDTH-1];
            if (!op_valid_s) begin
              result_r <= '0;
              ready_r  <= 1'b1;
            end else if (div_zero_s) begin
              result_r <= op_rem_s ? bus.idataa : {WIDTH{1'b1}};
              ready_r  <= 1'b1;
            end else begin
              ready_r  <= 1'b0;
            end
          end
        end
        ST_BUSY: begin
          rem_r <= rem_nxt_s;
          dvd_r <= quo_nxt_s;
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (last_iter_s) begin
            result_r <= final_s;
            ready_r  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!bus.istart) begin
            ready_r <= 1'b0;
          end
        end
        default: ready_r <= 1'b0;
      endcase
    end
  end

  assign bus.oresult = result_r;
  assign bus.oready  = ready_r;

endmodule

// File: doc/idiv_unit.md
# idiv_unit

Iterative 32-bit integer divide/remainder unit that acts as the responder on the same `istart`/`oready` coprocessor handshake the board top level uses to drive the FPALU. It latches two 32-bit operands and an operation code, runs a radix-2 restoring division at one quotient bit per clock, and holds the result with `oready` asserted until the host drops `istart`. It is instantiated beside the FPALU in the board top level, with the same operand registers and operation switches, and shares the result-display mux.

## Interface
Parameters:
- `WIDTH`, 32, operand and result width; only 32 is verified.

Ports:
- `iclock`  in  1  system clock; all state changes on its rising edge.
- `ireset`  in  1  reset; synchronous, active-high.
- `idataa`  in  32  dividend.
- `idatab`  in  32  divisor.
- `icontrol`  in  5  operation: 0 = DIV (signed), 1 = DIVU, 2 = REM (signed), 3 = REMU; 4..31 are invalid.
- `istart`  in  1  level-sensitive start request.
- `oresult`  out  32  result register.
- `oready`  out  1  high while a completed result is presented.

## Operation
- Three states: IDLE, BUSY, DONE.
- **Reset:** `ireset` = 1 at any edge, in any state, forces IDLE, `oresult` = 0, `oready` = 0, and the iteration counter to 0. A reset during BUSY discards the operation in progress.
- **IDLE:** `oready` = 0 and `oresult` holds its last value. When `istart` = 1 at an edge:
  - latch `idataa`, `idatab` and `icontrol`;
  - latch the absolute values of the operands for signed operations, or the raw values for unsigned operations;
  - record the quotient sign (sign(a) XOR sign(b)) and the remainder sign (sign(a));
  - clear the partial remainder.
- **IDLE next state:**
  - Invalid `icontrol`: DONE with `oresult` = 0.
  - Divisor = 0: DONE with `oresult` = 0xFFFFFFFF for DIV/DIVU, or the raw dividend for REM/REMU.
  - Otherwise: BUSY with counter = 0.
- **BUSY:** each cycle:
  - shift the partial remainder left by 1, bringing in the dividend MSB;
  - trial-subtract the divisor at 33 bits;
  - if the difference is non-negative, keep it and shift in quotient bit 1; otherwise shift in 0.
  - Exactly 32 iterations are run. On the edge that completes iteration 32, the state moves to DONE and `oresult` loads the quotient or remainder, negated in two's complement if the recorded sign requires it.
- **Overflow case:** 0x80000000 / 0xFFFFFFFF (DIV) gives 0x80000000, and REM gives 0. Both follow from unsigned magnitude arithmetic and need no special path.
- **BUSY is not interruptible:** changes on `idataa`, `idatab`, `icontrol` or `istart` during BUSY are ignored.
- **DONE:** `oready` = 1 and `oresult` is stable. Stay in DONE while `istart` = 1. When `istart` = 0 at an edge, go to IDLE: `oready` falls to 0 and `oresult` is held.
- **One operation per request:** a host that holds `istart` high gets exactly one operation. A new operation needs `istart` low for at least one edge.

## Timing
- Start sampled at edge N (IDLE, `istart` = 1) with a valid, nonzero-divisor request: BUSY covers edges N+1..N+32, and `oresult` and `oready` update at edge N+32. That is 32 cycles from start acceptance to ready.
- Divisor-zero or invalid op: DONE at edge N+1, so `oready` is high after 1 cycle.
- `istart` low at edge M in DONE: `oready` = 0 after edge M. The earliest next acceptance is edge M+1.
- `oresult` and `oready` are registered outputs with no combinational path from the inputs.
- Reset has priority over every other event at the same edge.

## Test plan
- DIVU 100 / 7: expect `oready` after 32 cycles with `oresult` = 14. Repeat with REMU: expect 2.
- DIV 0xFFFFFFF9 (-7) / 2: expect 0xFFFFFFFD (-3). REM with the same operands: expect 0xFFFFFFFF (-1). DIV 7 / 0xFFFFFFFE: expect 0xFFFFFFFD.
- Divisor 0, dividend 0x12345678:
  - DIVU expects 0xFFFFFFFF with `oready` 1 cycle after start;
  - REMU expects 0x12345678;
  - `icontrol` = 9 expects 0, also after 1 cycle.
- DIV 0x80000000 / 0xFFFFFFFF: expect 0x80000000. REM with the same operands: expect 0.
- Hold `istart` high for 100 cycles with DIVU 50 / 5: expect exactly one `oready` rise and `oresult` = 10. Drop `istart`: expect `oready` = 0 on the next edge with `oresult` still 10.
- Assert `ireset` at BUSY iteration 10: expect `oresult` = 0, `oready` = 0 and state IDLE. A fresh DIVU 9 / 3 then returns 3 after 32 cycles. Operand changes injected mid-BUSY must not alter the result.
